// File: rtl/seg7_pkg.sv
// Shared 7-segment constants and BCD-to-segment decode for the stopwatch display.
// Latency: n/a (constants and a combinational function only).
// Backpressure: n/a.
package seg7_pkg;

    // Segment patterns are {g, f, e, d, c, b, a}, active-low.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    // Non-BCD nibbles render as a dash so corrupt counter data is visible.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to active-low 7-segment pattern.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows input continuously.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    // Table lookup through the shared package function.
    always_comb begin
        seg = bcd_to_seg(nib);
    end

endmodule

// File: rtl/stopwatch_display_scan.sv
// Scans a 24-bit BCD time bus onto a 4-digit common-anode display, one digit per SCAN_DIV clocks.
// Latency: display follows idx by one edge; data_in reaches the display within 4*SCAN_DIV+1 cycles.
// Backpressure: none; data_in/page are sampled only at frame boundaries. Optional: LEADING_ZERO_BLANK_EN.
module stopwatch_display_scan
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int DIV_W    = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] data_in,
    input  logic        page,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    logic [DIV_W-1:0] prescaler;
    logic             tick;
    logic [1:0]       idx;
    logic             active;
    logic [23:0]      snap;
    logic             page_q;

    logic [4:0]       nib_base;
    logic [3:0]       nib;
    logic [6:0]       seg_dec;
    logic [3:0]       an_nxt;
    logic [6:0]       seg_nxt;
    logic             dp_nxt;

    assign tick = (prescaler == DIV_W'(SCAN_DIV - 1));

    // Prescaler: free-running 0..SCAN_DIV-1 divider that sets the digit slot length.
    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler <= '0;
        end else if (tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    // Digit index advances each slot; snapshot taken as idx wraps 3 -> 0 so a frame never tears.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx    <= 2'd3;
            active <= 1'b0;
            snap   <= 24'h0;
            page_q <= 1'b0;
        end else if (tick) begin
            idx    <= idx + 2'd1;
            active <= 1'b1;
            if (idx == 2'd3) begin
                snap   <= data_in;
                page_q <= page;
            end
        end
    end

    // Page 1 shifts the window up by two digits (one byte) to show minutes/seconds.
    assign nib_base = {1'b0, page_q, 3'b000} + {1'b0, idx, 2'b00};
    assign nib      = snap[nib_base +: 4];

    seg7_decode u_dec (
        .nib (nib),
        .seg (seg_dec)
    );

    // Next-output decode for the current slot, including optional leading-zero blanking.
    always_comb begin
        an_nxt  = ~(4'b0001 << idx);
        seg_nxt = seg_dec;
        dp_nxt  = (idx != 2'd2);
`ifdef LEADING_ZERO_BLANK_EN
        if ((idx == 2'd3) && (nib == 4'd0)) begin
            an_nxt  = AN_OFF;
            seg_nxt = SEG_BLANK;
        end
`endif
    end

    // Registered outputs; held dark until the first slot after reset.
    always_ff @(posedge clk) begin
        if (reset || !active) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= an_nxt;
            seg <= seg_nxt;
            dp  <= dp_nxt;
        end
    end

endmodule

// File: tb/tb_stopwatch_display_scan.sv
// Self-checking bench for stopwatch_display_scan: vector table, hand corner cases, random vs model.
// Latency: n/a.
// Backpressure: n/a.
module tb_stopwatch_display_scan;

    localparam int D    = 4;
    localparam int HMAX = 4096;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] data_in = 24'h0;
    logic        page = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int checks = 0;
    int errors = 0;

    stopwatch_display_scan #(.SCAN_DIV(D), .DIV_W(20)) dut (
        .clk     (clk),
        .reset   (reset),
        .data_in (data_in),
        .page    (page),
        .an      (an),
        .seg     (seg),
        .dp      (dp)
    );

    always #5 clk = ~clk;

    // Reference segment table, straight from the digit glyph list.
    logic [6:0] seg_tbl [16];

    // Edges since reset release, and the inputs seen at each of those edges.
    int          n = 0;
    logic [23:0] hist_d [HMAX];
    logic        hist_p [HMAX];

    always @(posedge clk) begin
        if (reset) n = 0;
        else       n = n + 1;
        if (n < HMAX) begin
            hist_d[n] = data_in;
            hist_p[n] = page;
        end
    end

    task automatic check(input string name, input logic [3:0] ea, input logic [6:0] es, input logic ed);
        checks++;
        if (an !== ea || seg !== es || dp !== ed) begin
            errors++;
            $display("FAIL %s: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                     name, an, seg, dp, ea, es, ed);
        end
    endtask

    // Expected outputs after edge t: slot m = (t-1)/D shows digit (m-1)%4 of the
    // inputs captured at the latest frame-start slot edge.
    task automatic model(input int t, output logic [3:0] ea, output logic [6:0] es, output logic ed);
        int m, d, ms;
        logic [23:0] v;
        logic pg;
        logic [3:0] nb;
        ea = 4'hF; es = 7'h7F; ed = 1'b1;
        if (t >= 1) begin
            m = (t - 1) / D;
            if (m >= 1) begin
                d  = (m - 1) % 4;
                ms = m - d;
                v  = hist_d[ms * D];
                pg = hist_p[ms * D];
                nb = 4'((v >> (4 * d + 8 * int'(pg))) & 24'hF);
                ea = ~(4'(1) << d);
                es = seg_tbl[nb];
                ed = (d != 2);
`ifdef LEADING_ZERO_BLANK_EN
                if (d == 3 && nb == 4'd0) begin
                    ea = 4'hF;
                    es = 7'h7F;
                end
`endif
            end
        end
    endtask

    task automatic do_reset(input int cyc);
        reset = 1'b1;
        repeat (cyc) begin
            @(posedge clk); #1;
            check("reset_blank", 4'hF, 7'h7F, 1'b1);
        end
        reset = 1'b0;
    endtask

    typedef struct {
        logic [23:0] d;
        logic        p;
        int          dig;
        logic [3:0]  ea;
        logic [6:0]  es;
        logic        ed;
    } vec_t;

    function automatic vec_t mk(logic [23:0] d, logic p, int dig, logic [3:0] ea, logic [6:0] es, logic ed);
        vec_t v;
        v.d = d; v.p = p; v.dig = dig; v.ea = ea; v.es = es; v.ed = ed;
        return v;
    endfunction

    vec_t vecs [14];

    initial begin
        logic [3:0] ea;
        logic [6:0] es;
        logic       ed;

        seg_tbl[0] = 7'b1000000; seg_tbl[1] = 7'b1111001; seg_tbl[2] = 7'b0100100;
        seg_tbl[3] = 7'b0110000; seg_tbl[4] = 7'b0011001; seg_tbl[5] = 7'b0010010;
        seg_tbl[6] = 7'b0000010; seg_tbl[7] = 7'b1111000; seg_tbl[8] = 7'b0000000;
        seg_tbl[9] = 7'b0010000;
        for (int i = 10; i < 16; i++) seg_tbl[i] = 7'b0111111;

        vecs[0]  = mk(24'h123456, 1'b0, 0, 4'b1110, 7'b0000010, 1'b1);
        vecs[1]  = mk(24'h123456, 1'b0, 1, 4'b1101, 7'b0010010, 1'b1);
        vecs[2]  = mk(24'h123456, 1'b0, 2, 4'b1011, 7'b0011001, 1'b0);
        vecs[3]  = mk(24'h123456, 1'b0, 3, 4'b0111, 7'b0110000, 1'b1);
        vecs[4]  = mk(24'h123456, 1'b1, 0, 4'b1110, 7'b0011001, 1'b1);
        vecs[5]  = mk(24'h123456, 1'b1, 1, 4'b1101, 7'b0110000, 1'b1);
        vecs[6]  = mk(24'h123456, 1'b1, 2, 4'b1011, 7'b0100100, 1'b0);
        vecs[7]  = mk(24'h123456, 1'b1, 3, 4'b0111, 7'b1111001, 1'b1);
        vecs[8]  = mk(24'h000512, 1'b0, 0, 4'b1110, 7'b0100100, 1'b1);
        vecs[9]  = mk(24'h000512, 1'b0, 1, 4'b1101, 7'b1111001, 1'b1);
        vecs[10] = mk(24'h000512, 1'b0, 2, 4'b1011, 7'b0010010, 1'b0);
`ifdef LEADING_ZERO_BLANK_EN
        vecs[11] = mk(24'h000512, 1'b0, 3, 4'b1111, 7'b1111111, 1'b1);
`else
        vecs[11] = mk(24'h000512, 1'b0, 3, 4'b0111, 7'b1000000, 1'b1);
`endif
        vecs[12] = mk(24'h00000A, 1'b0, 0, 4'b1110, 7'b0111111, 1'b1);
        vecs[13] = mk(24'h000099, 1'b1, 3, 4'b0111, 7'b1000000, 1'b1);
`ifdef LEADING_ZERO_BLANK_EN
        vecs[13] = mk(24'h000099, 1'b1, 3, 4'b1111, 7'b1111111, 1'b1);
`endif

        // Reset hold: blank throughout, first digit exactly at edge D+1.
        do_reset(5);
        data_in = 24'h123456; page = 1'b0;
        repeat (D) @(posedge clk);
        #1 check("pre_first_digit", 4'hF, 7'h7F, 1'b1);
        @(posedge clk); #1;
        check("first_digit", 4'b1110, 7'b0000010, 1'b1);

        // Vector table: one digit slot per record, fresh reset each time.
        for (int i = 0; i < 14; i++) begin
            do_reset(2);
            data_in = vecs[i].d;
            page    = vecs[i].p;
            repeat (D + 1 + vecs[i].dig * D) @(posedge clk);
            #1 check($sformatf("vec%0d", i), vecs[i].ea, vecs[i].es, vecs[i].ed);
        end

        // Mid-frame data change is held off until the next frame.
        do_reset(2);
        data_in = 24'h000011; page = 1'b0;
        repeat (D + 1) @(posedge clk);
        #1 check("tear_d0", 4'b1110, 7'b1111001, 1'b1);
        repeat (D - 1) @(posedge clk);
        #1 data_in = 24'h000099;
        @(posedge clk); #1 check("tear_d1_old", 4'b1101, 7'b1111001, 1'b1);
        repeat (D) @(posedge clk); #1 check("tear_d2_old", 4'b1011, 7'b1000000, 1'b0);
        repeat (D) @(posedge clk); #1 check("tear_d3_old", 4'b0111, 7'b1000000, 1'b1);
        repeat (D) @(posedge clk); #1 check("tear_d0_new", 4'b1110, 7'b0010000, 1'b1);
        repeat (D) @(posedge clk); #1 check("tear_d1_new", 4'b1101, 7'b0010000, 1'b1);

        // Reset asserted mid-frame blanks on the next edge and restarts at digit 0.
        do_reset(2);
        data_in = 24'h00000A; page = 1'b0;
        repeat (D + 1) @(posedge clk);
        #1 check("dash_d0", 4'b1110, 7'b0111111, 1'b1);
        repeat (6) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 check("midreset_blank", 4'hF, 7'h7F, 1'b1);
        reset = 1'b0;
        repeat (D) @(posedge clk);
        #1 check("midreset_still_blank", 4'hF, 7'h7F, 1'b1);
        @(posedge clk); #1 check("midreset_resume", 4'b1110, 7'b0111111, 1'b1);

        // Random phase: inputs change at random, occasional resets, checked every cycle.
        do_reset(1);
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            model(n, ea, es, ed);
            check("random", ea, es, ed);
            if ($urandom_range(0, 3) == 0) data_in = 24'($urandom);
            if ($urandom_range(0, 7) == 0) page = 1'($urandom);
            reset = ($urandom_range(0, 199) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
